// File: rtl/uart_pkg.sv
// Shared definitions for the uart_async block.
// Holds the frame size and the state encodings of the receive and transmit
// FSMs so the top level and the debug view in the interface agree on them.
package uart_pkg;

  localparam int DataBits = 8;

  typedef enum logic [2:0] {
    RxIdle,
    RxStart,
    RxData,
    RxStop,
    RxBreak
  } rx_state_e;

  typedef enum logic [2:0] {
    TxIdle,
    TxStart,
    TxData,
    TxStop
  } tx_state_e;

endpackage

// File: rtl/uart_async_if.sv
// Byte-side bus between uart_async and the serial controller.
//
// Handshake: every transfer is a one-cycle strobe with no back-pressure.
// The producer raises *_req for exactly one clk_i cycle with the byte valid
// in that same cycle; the consumer must take it then. On the transmit side
// tx_busy_o tells the controller when another request would be held or
// dropped, and a dropped request is reported by a one-cycle tx_ovf_o.
//
// Signals:
//   rx_req_o / rx_data_o / rx_err_o : received byte strobe, byte, framing error
//   tx_req_i / tx_data_i            : byte to send strobe and byte
//   tx_busy_o / tx_ovf_o            : transmitter busy, dropped-request strobe
//   rx_state / tx_state             : FSM state for observation only
// Modports: slave = the UART, master = the controller side.
interface uart_async_if;
  import uart_pkg::*;

  logic                rx_req_o;
  logic [DataBits-1:0] rx_data_o;
  logic                rx_err_o;
  logic                tx_req_i;
  logic [DataBits-1:0] tx_data_i;
  logic                tx_busy_o;
  logic                tx_ovf_o;
  rx_state_e           rx_state;
  tx_state_e           tx_state;

  modport slave (
    output rx_req_o, rx_data_o, rx_err_o, tx_busy_o, tx_ovf_o,
    output rx_state, tx_state,
    input  tx_req_i, tx_data_i
  );

  modport master (
    input  rx_req_o, rx_data_o, rx_err_o, tx_busy_o, tx_ovf_o,
    input  rx_state, tx_state,
    output tx_req_i, tx_data_i
  );

endinterface

// File: rtl/uart_async_sync_2ff.sv
// Two-flop synchronizer for a single asynchronous input.
// Ports:
//   clk_i  : destination clock
//   rst_ni : asynchronous active-low reset, both flops load ResetVal
//   d_i    : asynchronous input
//   q_o    : synchronized output
module sync_2ff #(
  parameter logic ResetVal = 1'b0
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic d_i,
  output logic q_o
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      meta_q <= ResetVal;
      sync_q <= ResetVal;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/uart_async.sv
// Full-duplex 8N1 UART between the serial pins and the byte-wide strobe bus.
// Ports:
//   clk_i  : single clock, rising edge
//   rst_ni : asynchronous active-low reset
//   rx_i   : serial input, idle high, asynchronous to clk_i
//   tx_o   : serial output, idle high
//   bus    : byte-side strobes (see uart_async_if), slave modport
// Parameter ClkPerBit: clock cycles per serial bit, at least 4.
module uart_async
  import uart_pkg::*;
#(
  parameter int ClkPerBit = 104
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         rx_i,
  output logic         tx_o,
  uart_async_if.slave  bus
);

  localparam int CntW = $clog2(ClkPerBit);
  localparam int BitW = $clog2(DataBits);
  localparam logic [CntW-1:0] CntFull = CntW'(ClkPerBit - 1);
  localparam logic [CntW-1:0] CntHalf = CntW'(ClkPerBit / 2 - 1);
  localparam logic [BitW-1:0] BitLast = BitW'(DataBits - 1);

  // ---------------------------------------------------------------- receive
  logic                rx_s;
  logic                rx_s_q;
  logic                rx_fall;
  rx_state_e           rx_state_q, rx_state_d;
  logic [CntW-1:0]     rx_cnt_q, rx_cnt_d;
  logic [BitW-1:0]     rx_bit_q, rx_bit_d;
  logic [DataBits-1:0] rx_shift_q, rx_shift_d;
  logic [DataBits-1:0] rx_data_q, rx_data_d;
  logic                rx_req_q, rx_req_d;
  logic                rx_err_q, rx_err_d;

  sync_2ff #(.ResetVal(1'b1)) u_rx_sync (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .d_i    (rx_i),
    .q_o    (rx_s)
  );

  // rx_s_q resets high, so a line already low at reset release only counts
  // once the synchronizer has actually produced a high-to-low transition.
  assign rx_fall = rx_s_q & ~rx_s;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rx_s_q     <= 1'b1;
      rx_state_q <= RxIdle;
      rx_cnt_q   <= '0;
      rx_bit_q   <= '0;
      rx_shift_q <= '0;
      rx_data_q  <= '0;
      rx_req_q   <= 1'b0;
      rx_err_q   <= 1'b0;
    end else begin
      rx_s_q     <= rx_s;
      rx_state_q <= rx_state_d;
      rx_cnt_q   <= rx_cnt_d;
      rx_bit_q   <= rx_bit_d;
      rx_shift_q <= rx_shift_d;
      rx_data_q  <= rx_data_d;
      rx_req_q   <= rx_req_d;
      rx_err_q   <= rx_err_d;
    end
  end

  always_comb begin
    rx_state_d = rx_state_q;
    rx_cnt_d   = rx_cnt_q;
    rx_bit_d   = rx_bit_q;
    rx_shift_d = rx_shift_q;
    rx_data_d  = rx_data_q;
    rx_req_d   = 1'b0;
    rx_err_d   = 1'b0;
    unique case (rx_state_q)
      RxIdle: begin
        if (rx_fall) begin
          rx_state_d = RxStart;
          rx_cnt_d   = CntHalf;
        end
      end
      RxStart: begin
        if (rx_cnt_q == '0) begin
          if (!rx_s) begin
            rx_state_d = RxData;
            rx_cnt_d   = CntFull;
            rx_bit_d   = '0;
          end else begin
            // Line went back high before mid start bit: treat as a glitch.
            rx_state_d = RxIdle;
          end
        end else begin
          rx_cnt_d = rx_cnt_q - 1'b1;
        end
      end
      RxData: begin
        if (rx_cnt_q == '0) begin
          rx_shift_d = {rx_s, rx_shift_q[DataBits-1:1]};
          rx_cnt_d   = CntFull;
          if (rx_bit_q == BitLast) begin
            rx_state_d = RxStop;
          end else begin
            rx_bit_d = rx_bit_q + 1'b1;
          end
        end else begin
          rx_cnt_d = rx_cnt_q - 1'b1;
        end
      end
      RxStop: begin
        if (rx_cnt_q == '0) begin
          if (rx_s) begin
            rx_data_d  = rx_shift_q;
            rx_req_d   = 1'b1;
            rx_state_d = RxIdle;
          end else begin
            rx_err_d   = 1'b1;
            rx_state_d = RxBreak;
          end
        end else begin
          rx_cnt_d = rx_cnt_q - 1'b1;
        end
      end
      RxBreak: begin
        // A low stop bit may be a break; wait for the line to recover so
        // the held-low period is not mistaken for a new start bit.
        if (rx_s) begin
          rx_state_d = RxIdle;
        end
      end
      default: rx_state_d = RxIdle;
    endcase
  end

  // --------------------------------------------------------------- transmit
  tx_state_e           tx_state_q, tx_state_d;
  logic [CntW-1:0]     tx_cnt_q, tx_cnt_d;
  logic [BitW-1:0]     tx_bit_q, tx_bit_d;
  logic [DataBits-1:0] tx_shift_q, tx_shift_d;
  logic                hold_full_q, hold_full_d;
  logic [DataBits-1:0] hold_data_q, hold_data_d;
  logic                tx_q, tx_d;
  logic                tx_busy_q, tx_busy_d;
  logic                tx_ovf_q, tx_ovf_d;
  logic                hold_take;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      tx_state_q  <= TxIdle;
      tx_cnt_q    <= '0;
      tx_bit_q    <= '0;
      tx_shift_q  <= '0;
      hold_full_q <= 1'b0;
      hold_data_q <= '0;
      tx_q        <= 1'b1;
      tx_busy_q   <= 1'b0;
      tx_ovf_q    <= 1'b0;
    end else begin
      tx_state_q  <= tx_state_d;
      tx_cnt_q    <= tx_cnt_d;
      tx_bit_q    <= tx_bit_d;
      tx_shift_q  <= tx_shift_d;
      hold_full_q <= hold_full_d;
      hold_data_q <= hold_data_d;
      tx_q        <= tx_d;
      tx_busy_q   <= tx_busy_d;
      tx_ovf_q    <= tx_ovf_d;
    end
  end

  always_comb begin
    tx_state_d  = tx_state_q;
    tx_cnt_d    = tx_cnt_q;
    tx_bit_d    = tx_bit_q;
    tx_shift_d  = tx_shift_q;
    hold_full_d = hold_full_q;
    hold_data_d = hold_data_q;
    tx_d        = tx_q;
    tx_ovf_d    = 1'b0;
    hold_take   = 1'b0;
    unique case (tx_state_q)
      TxIdle: begin
        if (bus.tx_req_i) begin
          tx_shift_d = bus.tx_data_i;
          tx_state_d = TxStart;
          tx_cnt_d   = CntFull;
          tx_d       = 1'b0;
        end
      end
      TxStart: begin
        if (tx_cnt_q == '0) begin
          tx_state_d = TxData;
          tx_cnt_d   = CntFull;
          tx_bit_d   = '0;
          tx_d       = tx_shift_q[0];
        end else begin
          tx_cnt_d = tx_cnt_q - 1'b1;
        end
      end
      TxData: begin
        if (tx_cnt_q == '0) begin
          tx_cnt_d = CntFull;
          if (tx_bit_q == BitLast) begin
            tx_state_d = TxStop;
            tx_d       = 1'b1;
          end else begin
            tx_bit_d   = tx_bit_q + 1'b1;
            tx_shift_d = {1'b0, tx_shift_q[DataBits-1:1]};
            tx_d       = tx_shift_d[0];
          end
        end else begin
          tx_cnt_d = tx_cnt_q - 1'b1;
        end
      end
      TxStop: begin
        if (tx_cnt_q == '0) begin
          if (hold_full_q) begin
            // Chain the held byte with no idle gap between frames.
            hold_take   = 1'b1;
            hold_full_d = 1'b0;
            tx_shift_d  = hold_data_q;
            tx_state_d  = TxStart;
            tx_cnt_d    = CntFull;
            tx_d        = 1'b0;
          end else begin
            tx_state_d = TxIdle;
          end
        end else begin
          tx_cnt_d = tx_cnt_q - 1'b1;
        end
      end
      default: tx_state_d = TxIdle;
    endcase

    // The holding slot frees up in the same cycle it is drained, so a
    // request landing exactly then is stored rather than dropped.
    if (bus.tx_req_i && (tx_state_q != TxIdle)) begin
      if (!hold_full_q || hold_take) begin
        hold_data_d = bus.tx_data_i;
        hold_full_d = 1'b1;
      end else begin
        tx_ovf_d = 1'b1;
      end
    end
  end

  assign tx_busy_d = (tx_state_d != TxIdle) || hold_full_d;

  // ---------------------------------------------------------------- outputs
  assign tx_o          = tx_q;
  assign bus.rx_req_o  = rx_req_q;
  assign bus.rx_data_o = rx_data_q;
  assign bus.rx_err_o  = rx_err_q;
  assign bus.tx_busy_o = tx_busy_q;
  assign bus.tx_ovf_o  = tx_ovf_q;
  assign bus.rx_state  = rx_state_q;
  assign bus.tx_state  = tx_state_q;

endmodule
